// File: rtl/press_sequencer_if.sv
// Button-in / pulse-out bundle for the Morse-style press sequencer.
// The driver of btn_i uses master; the sequencer itself uses slave.
interface press_sequencer_if;
    logic       btn_i;
    logic       dot_o;
    logic       dash_o;
    logic       illegal_o;
    logic       char_end_o;
    logic       word_end_o;
    logic [2:0] state_o;

    modport master (
        output btn_i,
        input  dot_o, dash_o, illegal_o, char_end_o, word_end_o, state_o
    );

    modport slave (
        input  btn_i,
        output dot_o, dash_o, illegal_o, char_end_o, word_end_o, state_o
    );
endinterface

// File: rtl/press_sequencer.sv
// Classifies button presses into dot/dash/illegal and gaps into character/word
// ends, timing every interval with one shared saturating counter.
module press_sequencer #(
    parameter int DASH_TICKS    = 3,
    parameter int ILLEGAL_TICKS = 8,
    parameter int CHAR_TICKS    = 4,
    parameter int WORD_TICKS    = 10
) (
    input  logic               clk,
    input  logic               reset,
    press_sequencer_if.slave   bus
);
    localparam int MAX_TICKS = (ILLEGAL_TICKS > WORD_TICKS) ? ILLEGAL_TICKS : WORD_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DASH_CNT    = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0] ILLEGAL_CNT = CNT_W'(ILLEGAL_TICKS);
    localparam logic [CNT_W-1:0] CHAR_CNT    = CNT_W'(CHAR_TICKS);
    localparam logic [CNT_W-1:0] WORD_CNT    = CNT_W'(WORD_TICKS);

    generate
        if (!(DASH_TICKS > 1 && DASH_TICKS < ILLEGAL_TICKS)) begin : g_bad_press_params
            $error("press_sequencer: need 1 < DASH_TICKS < ILLEGAL_TICKS");
        end
        if (!(CHAR_TICKS > 1 && CHAR_TICKS < WORD_TICKS)) begin : g_bad_gap_params
            $error("press_sequencer: need 1 < CHAR_TICKS < WORD_TICKS");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS     = 3'd1,
        HOLD      = 3'd2,
        GAP       = 3'd3,
        WAIT_WORD = 3'd4
    } state_e;

    state_e           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             dot_reg;
    logic             dash_reg;
    logic             illegal_reg;
    logic             char_end_reg;
    logic             word_end_reg;

    // Saturating increment: the counter never wraps back into a threshold.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            dot_reg      <= 1'b0;
            dash_reg     <= 1'b0;
            illegal_reg  <= 1'b0;
            char_end_reg <= 1'b0;
            word_end_reg <= 1'b0;
        end else begin
            dot_reg      <= 1'b0;
            dash_reg     <= 1'b0;
            illegal_reg  <= 1'b0;
            char_end_reg <= 1'b0;
            word_end_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.btn_i) begin
                        state_reg <= PRESS;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg <= '0;
                    end
                end

                PRESS: begin
                    if (bus.btn_i) begin
                        cnt_reg <= cnt_next;
                        if (cnt_next == ILLEGAL_CNT) begin
                            illegal_reg <= 1'b1;
                            state_reg   <= HOLD;
                        end
                    end else begin
                        // The release sample is the first low sample of the gap.
                        if (cnt_reg < DASH_CNT) begin
                            dot_reg <= 1'b1;
                        end else begin
                            dash_reg <= 1'b1;
                        end
                        state_reg <= GAP;
                        cnt_reg   <= CNT_ONE;
                    end
                end

                HOLD: begin
                    if (!bus.btn_i) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                GAP: begin
                    if (bus.btn_i) begin
                        state_reg <= PRESS;
                        cnt_reg   <= CNT_ONE;
                    end else begin
                        cnt_reg <= cnt_next;
                        if (cnt_next == CHAR_CNT) begin
                            char_end_reg <= 1'b1;
                            state_reg    <= WAIT_WORD;
                        end
                    end
                end

                WAIT_WORD: begin
                    if (bus.btn_i) begin
                        state_reg <= PRESS;
                        cnt_reg   <= CNT_ONE;
                    end else if (cnt_next == WORD_CNT) begin
                        word_end_reg <= 1'b1;
                        state_reg    <= IDLE;
                        cnt_reg      <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.dot_o      = dot_reg;
    assign bus.dash_o     = dash_reg;
    assign bus.illegal_o  = illegal_reg;
    assign bus.char_end_o = char_end_reg;
    assign bus.word_end_o = word_end_reg;
    assign bus.state_o    = state_reg;
endmodule

// File: tb/tb_press_sequencer.sv
// Directed bench for press_sequencer at default parameters, plus a random
// segment checking the one-hot and single-cycle pulse rules.
module tb_press_sequencer;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_DOT  = 5'b00001;
    localparam logic [4:0] P_DASH = 5'b00010;
    localparam logic [4:0] P_ILL  = 5'b00100;
    localparam logic [4:0] P_CHAR = 5'b01000;
    localparam logic [4:0] P_WORD = 5'b10000;

    press_sequencer_if bus ();

    press_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] pulses();
        return {bus.word_end_o, bus.char_end_o, bus.illegal_o, bus.dash_o, bus.dot_o};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive btn for n samples; only the last sample may produce exp_last.
    task automatic run(input logic b, input int n, input logic [4:0] exp_last, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.btn_i = b;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d]", tag, i), {3'b000, pulses()},
                {3'b000, (i == n - 1) ? exp_last : P_NONE});
        end
        $display("step %s btn=%0b x%0d state=%0d pulses=%05b", tag, b, n, bus.state_o, pulses());
    endtask

    task automatic chk_state(input string tag, input logic [2:0] exp);
        chk(tag, {5'b00000, bus.state_o}, {5'b00000, exp});
    endtask

    initial begin
        logic [4:0] p;
        logic [4:0] prev;
        logic       lvl;
        int         len;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.btn_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_pulses", {3'b000, pulses()}, 8'h00);
        chk_state("reset_state", 3'd0);
        reset = 1'b0;

        // Dot, then character and word gaps.
        run(1'b1, 1, P_NONE, "dot_press1");
        chk_state("dot_in_press", 3'd1);
        run(1'b1, 1, P_NONE, "dot_press2");
        run(1'b0, 1, P_DOT,  "dot_release");
        chk_state("dot_gap", 3'd3);
        run(1'b0, 3, P_CHAR, "dot_char");
        chk_state("dot_wait_word", 3'd4);
        run(1'b0, 6, P_WORD, "dot_word");
        chk_state("dot_idle", 3'd0);
        run(1'b0, 3, P_NONE, "idle_quiet");

        // Dash at both ends of its range.
        run(1'b1, 3, P_NONE, "dash3_press");
        run(1'b0, 1, P_DASH, "dash3_release");
        run(1'b0, 3, P_CHAR, "dash3_char");
        run(1'b0, 6, P_WORD, "dash3_word");
        run(1'b1, 7, P_NONE, "dash7_press");
        run(1'b0, 1, P_DASH, "dash7_release");
        run(1'b0, 3, P_CHAR, "dash7_char");
        run(1'b0, 6, P_WORD, "dash7_word");

        // Illegal press: pulse on the 8th high sample, then silence.
        run(1'b1, 8, P_ILL,  "ill_press");
        chk_state("ill_hold", 3'd2);
        run(1'b1, 4, P_NONE, "ill_hold_more");
        chk_state("ill_hold2", 3'd2);
        run(1'b0, 12, P_NONE, "ill_release");
        chk_state("ill_idle", 3'd0);

        // Gap interrupted before char end, then after char end before word end.
        run(1'b1, 2, P_NONE, "gap3_press");
        run(1'b0, 1, P_DOT,  "gap3_release");
        run(1'b0, 2, P_NONE, "gap3_low");
        run(1'b1, 2, P_NONE, "gap3_repress");
        chk_state("gap3_press_state", 3'd1);
        run(1'b0, 1, P_DOT,  "gap6_release");
        run(1'b0, 3, P_CHAR, "gap6_char");
        run(1'b0, 2, P_NONE, "gap6_low");
        chk_state("gap6_wait_state", 3'd4);
        run(1'b1, 2, P_NONE, "gap6_repress");
        chk_state("gap6_press_state", 3'd1);
        run(1'b0, 1, P_DOT,  "tail_release");
        run(1'b0, 3, P_CHAR, "tail_char");
        run(1'b0, 6, P_WORD, "tail_word");

        // Reset mid-press abandons the press.
        run(1'b1, 2, P_NONE, "rst_press");
        reset = 1'b1;
        bus.btn_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_pulses", {3'b000, pulses()}, 8'h00);
        chk_state("rst_mid_state", 3'd0);
        reset = 1'b0;
        run(1'b0, 12, P_NONE, "rst_after");
        chk_state("rst_after_state", 3'd0);

        // Random runs of high/low: at most one pulse, never two cycles long.
        prev = pulses();
        for (int r = 0; r < 80; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++) begin
                bus.btn_i = lvl;
                @(posedge clk);
                #1;
                p = pulses();
                chk("rand_onehot", {7'd0, $onehot0(p)}, 8'h01);
                chk("rand_single", {3'b000, p & prev}, 8'h00);
                prev = p;
            end
            $display("rand run %0d btn=%0b x%0d state=%0d", r, lvl, len, bus.state_o);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/press_sequencer.md
PRESS_SEQUENCER -- requirements
Module: press_sequencer

Interface
REQ-001 SHALL have parameter DASH_TICKS, default 3: minimum consecutive high samples classified as dash.
REQ-002 SHALL have parameter ILLEGAL_TICKS, default 8: consecutive high samples at which a press is illegal.
REQ-003 SHALL have parameter CHAR_TICKS, default 4: consecutive low samples ending a character.
REQ-004 SHALL have parameter WORD_TICKS, default 10: consecutive low samples ending a word.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port btn_i, input, 1: debounced button level, sampled every clk edge.
REQ-008 SHALL have port dot_o, output, 1: one-cycle pulse, dot classified.
REQ-009 SHALL have port dash_o, output, 1: one-cycle pulse, dash classified.
REQ-010 SHALL have port illegal_o, output, 1: one-cycle pulse, press exceeded ILLEGAL_TICKS.
REQ-011 SHALL have port char_end_o, output, 1: one-cycle pulse, character gap reached.
REQ-012 SHALL have port word_end_o, output, 1: one-cycle pulse, word gap reached.
REQ-013 SHALL have port state_o, output, 3: current FSM state encoding, for debug.

Function
REQ-014 SHALL time all four intervals with one shared counter cnt, width $clog2(max(ILLEGAL_TICKS,WORD_TICKS)+1), saturating at its maximum and never wrapping.
REQ-015 SHALL require 1 < DASH_TICKS < ILLEGAL_TICKS and 1 < CHAR_TICKS < WORD_TICKS; elaboration error otherwise.
REQ-016 SHALL implement states IDLE=0, PRESS=1, HOLD=2, GAP=3, WAIT_WORD=4; state_o equals the current state.
REQ-017 SHALL, in IDLE, GAP or WAIT_WORD, on sampling btn_i=1, move to PRESS with cnt=1.
REQ-018 SHALL, in PRESS, on btn_i=1, increment cnt; on cnt reaching ILLEGAL_TICKS, pulse illegal_o next cycle and move to HOLD.
REQ-019 SHALL, in PRESS, on btn_i=0, pulse dot_o next cycle if cnt < DASH_TICKS, else dash_o, and move to GAP with cnt=1.
REQ-020 SHALL, in HOLD, ignore btn_i=1 and on btn_i=0 move to IDLE with cnt=0, emitting no dot, dash, char_end or word_end.
REQ-021 SHALL, in GAP, on btn_i=0, increment cnt; on cnt reaching CHAR_TICKS, pulse char_end_o next cycle and move to WAIT_WORD.
REQ-022 SHALL, in WAIT_WORD, on btn_i=0, keep incrementing cnt; on cnt reaching WORD_TICKS, pulse word_end_o next cycle and move to IDLE with cnt=0.
REQ-023 SHALL, in IDLE, hold cnt=0 while btn_i=0 and emit no pulses.
REQ-024 SHALL suppress the pending char_end_o or word_end_o if btn_i=1 is sampled before the threshold is reached.
REQ-025 SHALL register all outputs; a pulse appears exactly one cycle after the deciding sample and lasts one cycle.
REQ-026 SHALL assert at most one of dot_o, dash_o, illegal_o, char_end_o, word_end_o in any cycle.

Reset
REQ-027 SHALL, while reset=1, force state IDLE, cnt=0, and all of dot_o, dash_o, illegal_o, char_end_o, word_end_o, state_o to 0 on the next edge.
REQ-028 SHALL abandon any in-progress press or gap on reset; a release following reset deassertion produces no dot or dash.
REQ-029 SHALL resume sampling btn_i on the first edge after reset deasserts.

Verification (default parameters)
REQ-030 SHALL cover: btn high 2 samples, then low -> dot_o 1 cycle after the first low sample; char_end_o after 4 low samples; word_end_o after 10; state_o=0.
REQ-031 SHALL cover: btn high 3 samples, then low -> dash_o only; high 7 samples, then low -> dash_o only.
REQ-032 SHALL cover: btn high 12 samples, then low 12 -> single illegal_o after the 8th high sample; no other pulses; state_o 2 then 0.
REQ-033 SHALL cover: dot, low 3, press -> no char_end_o; dot, low 6, press -> char_end_o once, no word_end_o.
REQ-034 SHALL cover: reset asserted during PRESS with cnt=2, then btn low 12 -> all outputs stay 0, state_o=0.
REQ-035 SHALL cover: random btn_i with assertions -> REQ-026 one-hot rule holds and every pulse lasts exactly one cycle.
